// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch path.
package rv_fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries with a single-cycle flush.
module fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (!push && pop) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;
  assign empty = (count_reg == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues credit-limited word reads and
// queues returned instructions for decode; redirects flush and drop stale reads.
module fetch_sequencer #(
  parameter int              XLEN     = rv_fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_pc,
  output logic [31:0]     fetch_instr,
  output logic            fetch_error
);

  import rv_fetch_pkg::*;

  localparam int            CW         = $clog2(DEPTH + 1);
  localparam logic [CW:0]   CREDIT_MAX = (CW + 1)'(DEPTH);

  fetch_state_t    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [CW-1:0]   outstanding_reg, outstanding_next;
  logic [CW-1:0]   drop_reg, drop_next;
  fetch_entry_t    hold_reg;

  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  fetch_entry_t    fifo_head;
  fetch_entry_t    push_entry;
  logic            push;
  logic            accept;
  logic [CW:0]     credit_used;
  logic            credit_ok;

  // ---------------- state machine ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= RUN;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (redirect_valid) begin
      state_next = (redirect_pc[1:0] == 2'b00) ? RUN : HALT;
    end
  end

  // Requests are held off while reset is asserted so the port idles immediately.
  always_comb begin
    fetch_error = (state_reg == HALT);
    imem_req    = (state_reg == RUN) && !redirect_valid && !reset && credit_ok;
  end

  // ---------------- PC, credit and drop accounting ----------------
  assign credit_used = {1'b0, outstanding_reg} + {1'b0, fifo_count};
  assign credit_ok   = (credit_used < CREDIT_MAX);

  always_comb begin
    pc_next          = pc_reg;
    outstanding_next = outstanding_reg;
    drop_next        = drop_reg;
    if (imem_req && !imem_rvalid) begin
      outstanding_next = outstanding_reg + 1'b1;
    end else if (!imem_req && imem_rvalid) begin
      outstanding_next = outstanding_reg - 1'b1;
    end
    if (imem_rvalid && (drop_reg != '0)) begin
      drop_next = drop_reg - 1'b1;
    end
    if (redirect_valid) begin
      pc_next   = redirect_pc;
      // Every read still in flight after this cycle belongs to the old stream.
      drop_next = outstanding_next;
    end else if (imem_req) begin
      pc_next = pc_reg + XLEN'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg          <= RESET_PC;
      outstanding_reg <= '0;
      drop_reg        <= '0;
      hold_reg        <= '0;
    end else begin
      pc_reg          <= pc_next;
      outstanding_reg <= outstanding_next;
      drop_reg        <= drop_next;
      if (!fifo_empty) hold_reg <= fifo_head;
    end
  end

  // ---------------- response capture ----------------
  // With nothing to drop, all reads in flight are live and were issued
  // back-to-back ending at pc_reg - 4, so the oldest one sits at pc_reg - 4*outstanding.
  always_comb begin
    push_entry.pc    = pc_reg - (XLEN'(outstanding_reg) * XLEN'(INSTR_BYTES));
    push_entry.instr = imem_rdata;
  end

  assign push   = imem_rvalid && (drop_reg == '0) && !redirect_valid;
  assign accept = fetch_valid && fetch_ready;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (accept),
    .flush     (redirect_valid),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign imem_addr   = pc_reg;
  assign fetch_valid = !fifo_empty;
  assign fetch_pc    = fifo_empty ? hold_reg.pc    : fifo_head.pc;
  assign fetch_instr = fifo_empty ? hold_reg.instr : fifo_head.instr;

  rvalid_has_owner: assert property (@(posedge clk) disable iff (reset)
    imem_rvalid |-> (outstanding_reg != '0));

endmodule
